// File: rtl/sprite_pkg.sv
// Shared constants, FSM state type and ROM addressing helper for the sprite blitter.
package sprite_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } blit_state_t;

  // Linear ROM address of sprite pixel (sx, sy); a flipped sprite reads its row right to left.
  function automatic int unsigned rom_addr_f(input int unsigned sx, input int unsigned sy,
                                             input logic flip, input int unsigned spr_w);
    int unsigned col;
    col = flip ? (spr_w - 1 - sx) : sx;
    return sy * spr_w + col;
  endfunction

endpackage

// File: rtl/sprite_scan_counter.sv
// Raster scan counter over the sprite: sx runs 0..SPR_W-1, sy steps at the end of each row.
module sprite_scan_counter #(
  parameter int unsigned SPR_W = 50,
  parameter int unsigned SPR_H = 64,
  parameter int unsigned SX_W  = (SPR_W > 1) ? $clog2(SPR_W) : 1,
  parameter int unsigned SY_W  = (SPR_H > 1) ? $clog2(SPR_H) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            clr_i,
  output logic [SX_W-1:0] sx_o,
  output logic [SY_W-1:0] sy_o,
  output logic            last_o
);

  logic [SX_W-1:0] sx_q, sx_d;
  logic [SY_W-1:0] sy_q, sy_d;
  logic            row_end;

  assign row_end = (sx_q == SX_W'(SPR_W - 1));
  assign last_o  = row_end && (sy_q == SY_W'(SPR_H - 1));
  assign sx_o    = sx_q;
  assign sy_o    = sy_q;

  // Next position: clear wins, otherwise advance in raster order and wrap after the last pixel.
  always_comb begin
    sx_d = sx_q;
    sy_d = sy_q;
    if (clr_i) begin
      sx_d = '0;
      sy_d = '0;
    end else if (en_i) begin
      if (row_end) begin
        sx_d = '0;
        sy_d = last_o ? '0 : sy_q + 1'b1;
      end else begin
        sx_d = sx_q + 1'b1;
      end
    end
  end

  // Counter state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sx_q <= '0;
      sy_q <= '0;
    end else begin
      sx_q <= sx_d;
      sy_q <= sy_d;
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Copies one sprite from a synchronous ROM into the palette-indexed frame buffer with
// placement, horizontal flip, edge clipping, transparency skip and write backpressure.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W       = 50,
  parameter int unsigned SPR_H       = 64,
  parameter int unsigned IDX_W       = 3,
  parameter int unsigned ROM_ADDR_W  = 12,
  parameter int unsigned FB_ADDR_W   = 19,
  parameter int unsigned TRANSPARENT = 0
) (
  input  logic                  vga_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [10:0]           pos_x,
  input  logic [10:0]           pos_y,
  input  logic                  flip_x,
  output logic [ROM_ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]      rom_q,
  output logic                  fb_we,
  output logic [FB_ADDR_W-1:0]  fb_addr,
  output logic [IDX_W-1:0]      fb_data,
  input  logic                  fb_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned SX_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int unsigned SY_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  blit_state_t state_q, state_d;

  logic [10:0] pos_x_q, pos_y_q;
  logic        flip_q;
  logic        latch;

  logic [SX_W-1:0] sx;
  logic [SY_W-1:0] sy;
  logic            last_px;
  logic            cnt_en, cnt_clr;

  // Stage 1: pixel whose ROM data is arriving on rom_q this cycle.
  logic                  s1_valid_q;
  logic [11:0]           s1_x_q, s1_y_q;
  logic [ROM_ADDR_W-1:0] s1_addr_q;
  logic                  s1_load, s1_clear;

  logic [ROM_ADDR_W-1:0] cur_addr;
  logic                  on_screen;
  logic                  stall;

  sprite_scan_counter #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H),
    .SX_W  (SX_W),
    .SY_W  (SY_W)
  ) u_scan (
    .clk_i  (vga_clk),
    .rst_i  (reset),
    .en_i   (cnt_en),
    .clr_i  (cnt_clr),
    .sx_o   (sx),
    .sy_o   (sy),
    .last_o (last_px)
  );

  assign cur_addr = ROM_ADDR_W'(rom_addr_f(32'(sx), 32'(sy), flip_q, SPR_W));

  // Write stage: clip to the screen and drop transparent indices.
  assign on_screen = !s1_x_q[11] && (s1_x_q < 12'(SCREEN_W)) &&
                     !s1_y_q[11] && (s1_y_q < 12'(SCREEN_H));
  assign fb_we     = s1_valid_q && on_screen && (rom_q != IDX_W'(TRANSPARENT));
  assign fb_data   = s1_valid_q ? rom_q : '0;
  assign fb_addr   = FB_ADDR_W'(s1_y_q) * FB_ADDR_W'(SCREEN_W) + FB_ADDR_W'(s1_x_q);
  assign stall     = fb_we && !fb_ready;

  // While stalled the ROM must re-read the pixel being written, not the next one, so rom_q
  // (and therefore fb_data) stays put until the write is accepted.
  assign rom_address = stall ? s1_addr_q : cur_addr;

  // FSM next-state and control decode.
  always_comb begin
    state_d  = state_q;
    latch    = 1'b0;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b0;
    s1_load  = 1'b0;
    s1_clear = 1'b0;
    done     = 1'b0;
    busy     = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          latch   = 1'b1;
          cnt_clr = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (!stall) begin
          cnt_en  = 1'b1;
          s1_load = 1'b1;
          if (last_px) state_d = StDrain;
        end
      end
      StDrain: begin
        if (!stall) begin
          s1_clear = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        cnt_clr = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Placement and flip are captured once per blit.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      pos_x_q <= '0;
      pos_y_q <= '0;
      flip_q  <= 1'b0;
    end else if (latch) begin
      pos_x_q <= pos_x;
      pos_y_q <= pos_y;
      flip_q  <= flip_x;
    end
  end

  // Stage 1 register: screen coordinates are 12-bit signed so negative placements clip cleanly.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_addr_q  <= '0;
    end else if (s1_load) begin
      s1_valid_q <= 1'b1;
      s1_x_q     <= {pos_x_q[10], pos_x_q} + 12'(sx);
      s1_y_q     <= {pos_y_q[10], pos_y_q} + 12'(sy);
      s1_addr_q  <= cur_addr;
    end else if (s1_clear) begin
      s1_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: placement, flip, clipping, backpressure, reset, start guard.
module tb_sprite_blitter;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] pos_x, pos_y;
  logic        flip_x;
  logic [11:0] rom_address;
  logic [2:0]  rom_q = 3'd0;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_ready;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int rom_mode = 0;  // 0: q = addr % 8, 1: all transparent

  // Observations gathered by run_blit.
  int   o_nwr, o_lat, o_first_addr, o_first_data, o_probe_data;
  int   o_model_bad, o_order_bad, o_stable_bad, o_extra_done, o_timeout;
  logic o_busy_start, o_busy_after, o_rst_we, o_rst_busy, o_rst_done;

  sprite_blitter u_dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .start       (start),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .flip_x      (flip_x),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_ready    (fb_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 vga_clk = ~vga_clk;

  // Synchronous sprite ROM model.
  always @(posedge vga_clk) rom_q <= (rom_mode != 0) ? 3'd0 : rom_address[2:0];

  task automatic run_blit(input int px, input int py, input bit flip, input bit do_stall,
                          input bit do_restart, input int abort_at, input int probe_addr);
    int cyc, last_a, a, x, y, sx, sy, ra, expd, stall_left;
    bit stalled_once;
    logic [18:0] h_addr;
    logic [2:0]  h_data;
    o_nwr = 0; o_lat = -1; o_first_addr = -1; o_first_data = -1; o_probe_data = -1;
    o_model_bad = 0; o_order_bad = 0; o_stable_bad = 0; o_extra_done = 0; o_timeout = 0;
    stall_left = 0; stalled_once = 0; last_a = -1; cyc = 0;
    h_addr = '0; h_data = '0;
    @(posedge vga_clk); #1;
    pos_x = px[10:0]; pos_y = py[10:0]; flip_x = flip; start = 1'b1;
    @(posedge vga_clk); #1;  // acceptance edge has passed
    start = 1'b0;
    while (1) begin
      @(negedge vga_clk);
      cyc++;
      if (cyc == 1) o_busy_start = busy;
      if (do_restart) start = (cyc == 50);
      if (stall_left > 0) begin
        if (fb_we !== 1'b1 || fb_addr !== h_addr || fb_data !== h_data) o_stable_bad++;
        stall_left--;
        if (stall_left == 0) fb_ready = 1'b1;
      end else if (do_stall && !stalled_once && fb_we && o_nwr == 2) begin
        stalled_once = 1; fb_ready = 1'b0; stall_left = 5; h_addr = fb_addr; h_data = fb_data;
      end
      if (fb_we === 1'b1 && fb_ready) begin
        a = int'(fb_addr);
        if (o_nwr == 0) begin o_first_addr = a; o_first_data = int'(fb_data); end
        if (a == probe_addr) o_probe_data = int'(fb_data);
        if (a <= last_a) o_order_bad++;
        last_a = a;
        x = a % 640; y = a / 640; sx = x - px; sy = y - py;
        if (sx < 0 || sx > 49 || sy < 0 || sy > 63) begin
          o_model_bad++;
        end else begin
          ra = sy * 50 + (flip ? 49 - sx : sx);
          expd = (rom_mode != 0) ? 0 : ra % 8;
          if (int'(fb_data) != expd || fb_data == 3'd0) o_model_bad++;
        end
        o_nwr++;
      end
      if (abort_at >= 0 && o_nwr == abort_at) begin
        reset = 1'b1; #1;
        o_rst_we = fb_we; o_rst_busy = busy; o_rst_done = done;
        fb_ready = 1'b1;
        @(posedge vga_clk); @(posedge vga_clk); #1;
        reset = 1'b0;
        return;
      end
      if (done === 1'b1) begin o_lat = cyc; break; end
      if (cyc > 4000) begin o_timeout = 1; break; end
    end
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge vga_clk);
      if (done === 1'b1) o_extra_done++;
      o_busy_after = busy;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; fb_ready = 1'b1; pos_x = '0; pos_y = '0; flip_x = 1'b0;
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    total++; if (fb_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", fb_we); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (rom_address !== 12'd0) begin
      bad++; $display("FAIL reset_rom_addr: got %0d want 0", rom_address); end
    total++; if (fb_addr !== 19'd0) begin
      bad++; $display("FAIL reset_fb_addr: got %0d want 0", fb_addr); end
    total++; if (fb_data !== 3'd0) begin
      bad++; $display("FAIL reset_fb_data: got %0d want 0", fb_data); end
    #1 reset = 1'b0;
  endtask

  task automatic test_basic();
    rom_mode = 0;
    run_blit(0, 0, 1'b0, 1'b0, 1'b0, -1, 1283);
    total++; if (o_timeout != 0) begin bad++; $display("FAIL basic_timeout: got 1 want 0"); end
    total++; if (o_nwr != 2800) begin bad++; $display("FAIL basic_writes: got %0d want 2800", o_nwr); end
    total++; if (o_lat != 3202) begin bad++; $display("FAIL basic_latency: got %0d want 3202", o_lat); end
    total++; if (o_probe_data != 7) begin
      bad++; $display("FAIL basic_px_3_2: got %0d want 7", o_probe_data); end
    total++; if (o_model_bad != 0) begin
      bad++; $display("FAIL basic_data: got %0d bad writes want 0", o_model_bad); end
    total++; if (o_order_bad != 0) begin
      bad++; $display("FAIL basic_order: got %0d repeats want 0", o_order_bad); end
    total++; if (o_busy_start !== 1'b1) begin
      bad++; $display("FAIL basic_busy_start: got %b want 1", o_busy_start); end
    total++; if (o_extra_done != 0) begin
      bad++; $display("FAIL basic_done_once: got %0d extra want 0", o_extra_done); end
    total++; if (o_busy_after !== 1'b0) begin
      bad++; $display("FAIL basic_busy_after: got %b want 0", o_busy_after); end
  endtask

  task automatic test_flip();
    rom_mode = 0;
    run_blit(100, 10, 1'b1, 1'b0, 1'b0, -1, 6500);
    total++; if (o_nwr != 2800) begin bad++; $display("FAIL flip_writes: got %0d want 2800", o_nwr); end
    total++; if (o_first_addr != 6500) begin
      bad++; $display("FAIL flip_first_addr: got %0d want 6500", o_first_addr); end
    total++; if (o_first_data != 1) begin
      bad++; $display("FAIL flip_first_data: got %0d want 1", o_first_data); end
    total++; if (o_model_bad != 0) begin
      bad++; $display("FAIL flip_data: got %0d bad writes want 0", o_model_bad); end
    total++; if (o_lat != 3202) begin bad++; $display("FAIL flip_latency: got %0d want 3202", o_lat); end
  endtask

  task automatic test_clip();
    rom_mode = 0;
    run_blit(-10, 450, 1'b0, 1'b0, 1'b0, -1, -1);
    // 40 visible columns x 30 visible rows, 5 transparent per row.
    total++; if (o_nwr != 1050) begin bad++; $display("FAIL clip_writes: got %0d want 1050", o_nwr); end
    total++; if (o_first_addr != 288000) begin
      bad++; $display("FAIL clip_first_addr: got %0d want 288000", o_first_addr); end
    total++; if (o_first_data != 2) begin
      bad++; $display("FAIL clip_first_data: got %0d want 2", o_first_data); end
    total++; if (o_model_bad != 0) begin
      bad++; $display("FAIL clip_data: got %0d bad writes want 0", o_model_bad); end
    total++; if (o_lat != 3202) begin bad++; $display("FAIL clip_latency: got %0d want 3202", o_lat); end
  endtask

  task automatic test_backpressure();
    rom_mode = 0;
    run_blit(0, 0, 1'b0, 1'b1, 1'b0, -1, -1);
    total++; if (o_stable_bad != 0) begin
      bad++; $display("FAIL bp_stable: got %0d unstable cycles want 0", o_stable_bad); end
    total++; if (o_nwr != 2800) begin bad++; $display("FAIL bp_writes: got %0d want 2800", o_nwr); end
    total++; if (o_order_bad != 0) begin
      bad++; $display("FAIL bp_order: got %0d repeats want 0", o_order_bad); end
    total++; if (o_model_bad != 0) begin
      bad++; $display("FAIL bp_data: got %0d bad writes want 0", o_model_bad); end
    total++; if (o_lat != 3207) begin bad++; $display("FAIL bp_latency: got %0d want 3207", o_lat); end
  endtask

  task automatic test_reset_mid();
    rom_mode = 0;
    run_blit(0, 0, 1'b0, 1'b0, 1'b0, 100, -1);
    total++; if (o_rst_we !== 1'b0) begin bad++; $display("FAIL rstmid_we: got %b want 0", o_rst_we); end
    total++; if (o_rst_busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_busy: got %b want 0", o_rst_busy); end
    total++; if (o_rst_done !== 1'b0) begin
      bad++; $display("FAIL rstmid_done: got %b want 0", o_rst_done); end
    @(negedge vga_clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_idle: got %b want 0", busy); end
    run_blit(0, 0, 1'b0, 1'b0, 1'b0, -1, -1);
    total++; if (o_nwr != 2800) begin
      bad++; $display("FAIL rstmid_rerun_writes: got %0d want 2800", o_nwr); end
    total++; if (o_model_bad != 0) begin
      bad++; $display("FAIL rstmid_rerun_data: got %0d bad writes want 0", o_model_bad); end
    total++; if (o_lat != 3202) begin
      bad++; $display("FAIL rstmid_rerun_latency: got %0d want 3202", o_lat); end
  endtask

  task automatic test_start_busy();
    rom_mode = 1;
    run_blit(20, 20, 1'b0, 1'b0, 1'b1, -1, -1);
    total++; if (o_nwr != 0) begin bad++; $display("FAIL sb_writes: got %0d want 0", o_nwr); end
    total++; if (o_lat != 3202) begin bad++; $display("FAIL sb_latency: got %0d want 3202", o_lat); end
    total++; if (o_extra_done != 0) begin
      bad++; $display("FAIL sb_done_once: got %0d extra want 0", o_extra_done); end
    total++; if (o_busy_after !== 1'b0) begin
      bad++; $display("FAIL sb_busy_after: got %b want 0", o_busy_after); end
    rom_mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flip();
    test_clip();
    test_backpressure();
    test_reset_mid();
    test_start_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
